// File: rtl/width_serializer_if.sv
// Valid/ready channel carrying a W-bit payload; producer drives valid/data, consumer drives ready.
// master/slave are aliases of producer/consumer for blocks that use that naming.
interface width_serializer_if #(
   parameter int W = 8
);
   logic         valid;
   logic         ready;
   logic [W-1:0] data;

   modport producer (output valid, output data, input  ready);
   modport consumer (input  valid, input  data, output ready);
   modport master   (output valid, output data, input  ready);
   modport slave    (input  valid, input  data, output ready);
endinterface

// File: rtl/width_serializer.sv
// Splits one NO-word input beat into len_m1+1 output words; first word appears the cycle after the beat is accepted.
// A new beat is accepted only while idle or on the final word's handshake; dout stalls hold everything and block din.
module width_serializer #(
   parameter int W_DATA    = 16,
   parameter int NO        = 4,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   width_serializer_if.consumer  din,
   width_serializer_if.producer  dout
);
   localparam int W_CNT   = (NO > 1) ? $clog2(NO) : 1;
   localparam int W_WORDS = NO * W_DATA;
   localparam int W_DIN   = 1 + W_CNT + W_WORDS;

   typedef logic [NO-1:0][W_DATA-1:0] words_t;
   typedef enum logic {IDLE, SEND} state_t;

   state_t             state, state_nxt;
   words_t             buf_words, in_words;
   logic [W_CNT-1:0]   buf_len, in_len, cnt, cnt_inc;
   logic               buf_eot, in_eot;
   logic [W_DATA-1:0]  out_word;
   logic               out_last, out_eot;
   logic               din_ready_c, load, adv;

   function automatic logic [W_CNT-1:0] clamp_len(input logic [W_CNT-1:0] l);
      logic [W_CNT-1:0] r;
      r = l;
      if (int'(l) > NO - 1) r = W_CNT'(NO - 1);
      return r;
   endfunction

   // Word at output position idx of a beat with (clamped) length len.
   function automatic logic [W_DATA-1:0] pick(input words_t w, input logic [W_CNT-1:0] len,
                                              input logic [W_CNT-1:0] idx);
      logic [W_CNT-1:0]  pos;
      logic [W_DATA-1:0] r;
      pos = MSB_FIRST ? (len - idx) : idx;
      r   = '0;
      for (int i = 0; i < NO; i++)
         if (W_CNT'(i) == pos) r = w[i];
      return r;
   endfunction

   assign in_words = din.data[W_WORDS-1:0];
   assign in_len   = clamp_len(din.data[W_WORDS +: W_CNT]);
   assign in_eot   = din.data[W_DIN-1];
   assign cnt_inc  = cnt + 1'b1;

   always_comb begin
      state_nxt   = state;
      din_ready_c = 1'b0;
      case (state)
         IDLE: begin
            din_ready_c = 1'b1;
            if (din.valid) state_nxt = SEND;
         end
         SEND: begin
            if (dout.ready && out_last) begin
               din_ready_c = 1'b1;
               state_nxt   = din.valid ? SEND : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (rst) din_ready_c = 1'b0;
   end

   assign load = din.valid && din_ready_c;
   assign adv  = (state == SEND) && dout.ready && !out_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         out_word <= '0;
         out_last <= 1'b0;
         out_eot  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (load) begin
            cnt      <= '0;
            out_word <= pick(in_words, in_len, '0);
            out_last <= (in_len == '0);
            out_eot  <= in_eot && (in_len == '0);
         end else if (adv) begin
            cnt      <= cnt_inc;
            out_word <= pick(buf_words, buf_len, cnt_inc);
            out_last <= (cnt_inc == buf_len);
            out_eot  <= buf_eot && (cnt_inc == buf_len);
         end
      end
   end

   // Beat storage needs no reset: it is only read after a load.
   always_ff @(posedge clk) begin
      if (load) begin
         buf_words <= in_words;
         buf_len   <= in_len;
         buf_eot   <= in_eot;
      end
   end

   assign din.ready  = din_ready_c;
   assign dout.valid = (state == SEND);
   assign dout.data  = {out_eot, out_last, out_word};
endmodule

// File: tb/tb_width_serializer.sv
// Drives two serializers (LSB-first and MSB-first) with identical stimulus and checks them against a word-queue model.
module tb_width_serializer;
   localparam int W_IN  = 67;
   localparam int W_OUT = 18;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic            in_valid  = 1'b0;
   logic [W_IN-1:0] in_data   = '0;
   logic            out_ready = 1'b1;

   width_serializer_if #(.W(W_IN))  din0 ();
   width_serializer_if #(.W(W_IN))  din1 ();
   width_serializer_if #(.W(W_OUT)) dout0 ();
   width_serializer_if #(.W(W_OUT)) dout1 ();

   assign din0.valid  = in_valid;
   assign din0.data   = in_data;
   assign din1.valid  = in_valid;
   assign din1.data   = in_data;
   assign dout0.ready = out_ready;
   assign dout1.ready = out_ready;

   width_serializer #(.W_DATA(16), .NO(4), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .din(din0), .dout(dout0));
   width_serializer #(.W_DATA(16), .NO(4), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .din(din1), .dout(dout1));

   int checks = 0;
   int errors = 0;
   logic [W_OUT-1:0] q0[$];
   logic [W_OUT-1:0] q1[$];
   bit exp_rdy;

   task automatic chk(input string name, input logic [W_OUT-1:0] act, input logic [W_OUT-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [W_IN-1:0] beat(input bit eot, input int len, input logic [15:0] w3,
                                            input logic [15:0] w2, input logic [15:0] w1,
                                            input logic [15:0] w0);
      return {eot, len[1:0], w3, w2, w1, w0};
   endfunction

   // Expected output stream of one beat: {eot_o, last, word} per word, for both word orders.
   task automatic push_beat(input logic [W_IN-1:0] d);
      int  n;
      bit  last;
      bit  eot;
      n   = int'(d[65:64]) + 1;
      if (n > 4) n = 4;
      eot = d[66];
      for (int i = 0; i < n; i++) begin
         last = (i == n - 1);
         q0.push_back({eot && last, last, d[16*i +: 16]});
         q1.push_back({eot && last, last, d[16*(n-1-i) +: 16]});
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_din_ready0", din0.ready, 1'b0);
         chk("rst_din_ready1", din1.ready, 1'b0);
         q0.delete();
         q1.delete();
      end else begin
         exp_rdy = (q0.size() == 0) || (out_ready && q0[0][16]);
         chk("dout_valid0", dout0.valid, q0.size() != 0);
         chk("dout_valid1", dout1.valid, q1.size() != 0);
         if (q0.size() != 0) chk("dout_data0", dout0.data, q0[0]);
         if (q1.size() != 0) chk("dout_data1", dout1.data, q1[0]);
         chk("din_ready0", din0.ready, exp_rdy);
         chk("din_ready1", din1.ready, exp_rdy);
         if (out_ready && q0.size() != 0) void'(q0.pop_front());
         if (out_ready && q1.size() != 0) void'(q1.pop_front());
         if (in_valid && exp_rdy) push_beat(in_data);
      end
   end

   task automatic out_chk(input string name, input bit v, input logic [W_OUT-1:0] d0,
                          input logic [W_OUT-1:0] d1);
      @(negedge clk);
      chk({name, "_valid"}, dout0.valid, v);
      if (v) begin
         chk({name, "_lsb"}, dout0.data, d0);
         chk({name, "_msb"}, dout1.data, d1);
      end
   endtask

   task automatic drive(input logic [W_IN-1:0] d);
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   initial begin
      int  sent;
      int  cyc;
      bit  taken;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", din0.ready, 1'b1);
      chk("post_rst_valid", dout0.valid, 1'b0);

      // Four words LSB-first, eot only on the last.
      drive(beat(1'b1, 3, 16'hD, 16'hC, 16'hB, 16'hA));
      out_chk("t1w0", 1'b1, 18'h0000A, 18'h0000D);
      out_chk("t1w1", 1'b1, 18'h0000B, 18'h0000C);
      out_chk("t1w2", 1'b1, 18'h0000C, 18'h0000B);
      out_chk("t1w3", 1'b1, 18'h3000D, 18'h3000A);
      out_chk("t1end", 1'b0, 18'h0, 18'h0);

      // Two-word beat, eot clear.
      drive(beat(1'b0, 1, 16'h0, 16'h0, 16'h22, 16'h11));
      out_chk("t2w0", 1'b1, 18'h00011, 18'h00022);
      out_chk("t2w1", 1'b1, 18'h10022, 18'h10011);
      out_chk("t2end", 1'b0, 18'h0, 18'h0);

      // Back-to-back beats with din.valid held: five words, no bubble.
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = beat(1'b0, 3, 16'h4, 16'h3, 16'h2, 16'h1);
      @(posedge clk); #1;
      in_data  = beat(1'b1, 0, 16'h9, 16'h9, 16'h9, 16'h5);
      for (int i = 0; i < 5; i++) begin
         if (i < 4)
            out_chk("t3w", 1'b1, {1'b0, i == 3, 16'(i + 1)}, {1'b0, i == 3, 16'(4 - i)});
         else
            out_chk("t3w", 1'b1, 18'h30005, 18'h30005);
         chk("t3_din_ready", din0.ready, i >= 3);
         @(posedge clk); #1;
         if (i == 3) in_valid = 1'b0;
      end
      out_chk("t3end", 1'b0, 18'h0, 18'h0);

      // Reset after two words discards the rest.
      drive(beat(1'b1, 3, 16'h13, 16'h12, 16'h11, 16'h10));
      out_chk("t4w0", 1'b1, 18'h00010, 18'h00013);
      out_chk("t4w1", 1'b1, 18'h00011, 18'h00012);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("t4_valid_after_rst", dout0.valid, 1'b0);
      chk("t4_ready_after_rst", din0.ready, 1'b1);
      drive(beat(1'b0, 2, 16'h0, 16'h22, 16'h21, 16'h20));
      out_chk("t4next", 1'b1, 18'h00020, 18'h00022);
      repeat (4) @(posedge clk);

      // Oversized length field: exactly four words, last on the fourth.
      drive(beat(1'b1, 7, 16'h34, 16'h33, 16'h32, 16'h31));
      out_chk("t5w0", 1'b1, 18'h00031, 18'h00034);
      out_chk("t5w1", 1'b1, 18'h00032, 18'h00033);
      out_chk("t5w2", 1'b1, 18'h00033, 18'h00032);
      out_chk("t5w3", 1'b1, 18'h30034, 18'h30031);
      out_chk("t5end", 1'b0, 18'h0, 18'h0);

      // Random beats under random output backpressure.
      sent = 0;
      cyc  = 0;
      while (sent < 1000 && cyc < 20000) begin
         @(negedge clk);
         taken = in_valid && din0.ready;
         @(posedge clk); #1;
         cyc++;
         if (taken) sent++;
         out_ready = ($urandom % 2) == 0;
         if (!in_valid || taken) begin
            in_valid = ($urandom % 4) != 0;
            in_data  = W_IN'({$urandom, $urandom, $urandom});
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("random_beats_sent", sent >= 1000, 1'b1);
      for (int i = 0; i < 10 && q0.size() != 0; i++) @(posedge clk);
      @(posedge clk);
      chk("drain_empty", q0.size() == 0, 1'b1);
      @(negedge clk);
      chk("drain_valid", dout0.valid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/width_serializer.md
WIDTH_SERIALIZER -- requirements
Module: width_serializer

Interface
REQ-001 Parameter W_DATA, default 16, width of one output word in bits.
REQ-002 Parameter NO, default 4, maximum words per input beat (NO >= 1).
REQ-003 Parameter MSB_FIRST, default 0; 0 emits word 0 first, 1 emits highest valid word first.
REQ-004 Derived W_CNT = max(1, $clog2(NO)); not overridable.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 din  dti.consumer  1+W_CNT+NO*W_DATA  data = {eot, len_m1[W_CNT-1:0], word[NO-1:0][W_DATA-1:0]}; valid/ready handshake.
REQ-008 dout  dti.producer  2+W_DATA  data = {eot_o, last, word[W_DATA-1:0]}; valid/ready handshake.

Function
REQ-009 The block SHALL be a two-state FSM: IDLE (no beat buffered) and SEND (beat buffered, words pending).
REQ-010 On a din handshake the block SHALL capture words, len_m1 and eot into an internal buffer, clear the word counter cnt to 0 and enter SEND.
REQ-011 din.ready SHALL be 1 in IDLE, and in SEND only in the cycle the final word is handshaked on dout.
REQ-012 din.ready SHALL NOT depend combinationally on din.valid.
REQ-013 dout.valid SHALL be 1 exactly while in SEND; dout.valid and dout.data SHALL be driven from registers only.
REQ-014 Latency: a beat accepted in cycle N SHALL present its first word on dout in cycle N+1.
REQ-015 Word count per beat SHALL be len_m1+1 (1..NO); len_m1 >= NO SHALL be clamped to NO-1.
REQ-016 Word order: MSB_FIRST=0 emits word[cnt]; MSB_FIRST=1 emits word[len_m1-cnt].
REQ-017 cnt SHALL increment by 1 on each dout handshake and never exceed the clamped len_m1.
REQ-018 dout last SHALL be 1 iff cnt == clamped len_m1.
REQ-019 dout eot_o SHALL equal captured eot AND last; 0 on all non-final words.
REQ-020 Final-word handshake with din.valid=1 SHALL load the next beat in the same cycle and stay in SEND, giving one word per cycle with no bubble between beats.
REQ-021 Final-word handshake with din.valid=0 SHALL return to IDLE; dout.valid=0 next cycle.
REQ-022 While dout.ready=0, dout.data, cnt and the buffer SHALL hold unchanged and din.ready SHALL be 0.
REQ-023 With NO=1 every word SHALL have last=1 and the block SHALL sustain one beat per cycle.
REQ-024 Unused buffer words (index > len_m1) SHALL never appear on dout.

Reset
REQ-025 rst=1 at a clock edge SHALL force state IDLE, cnt=0, dout.valid=0; buffer contents are don't-care.
REQ-026 The first cycle after rst deasserts SHALL have din.ready=1, dout.valid=0.
REQ-027 rst asserted mid-SEND SHALL discard the remaining words of the buffered beat; no partial word is emitted after reset.
REQ-028 din.ready SHALL be 0 in any cycle in which rst=1.

Verification
REQ-029 NO=4, MSB_FIRST=0, dout.ready=1, one beat words {D,C,B,A} (word0=A), len_m1=3, eot=1 -> A,B,C,D on 4 consecutive cycles starting N+1; last=1 and eot_o=1 only on D; dout.valid=0 after.
REQ-030 MSB_FIRST=1, len_m1=1, words {x,x,0x22,0x11}, eot=0 -> 0x22 then 0x11; last=1 on 0x11; eot_o=0 throughout.
REQ-031 Back-to-back beats len_m1=3 and len_m1=0, din.valid held 1, dout.ready=1 -> 5 words on 5 consecutive cycles, no bubble; din.ready high only in the cycle of each final-word handshake plus the initial IDLE cycle.
REQ-032 Random dout.ready backpressure (~50%) over 1000 random beats -> scoreboard matches word order, last, eot_o exactly; dout.data stable while valid&&!ready.
REQ-033 rst pulsed after 2 of 4 words -> no further words emitted; dout.valid=0 the cycle after reset; next beat transmitted from its word 0.
REQ-034 len_m1=7 with NO=4 -> exactly 4 words emitted, last on the fourth.
